fetch_queue: RTL and testbench
==============================

Name: fetch_queue

Overview:
- Consumer side of the program-counter interface.
- Takes the instruction address driven by the PC register and fetches it from instruction memory over a req/ready handshake.
- Buffers fetched {pc, instruction} pairs in a small FIFO toward decode.
- Drives the PC's stall input and flushes on branch redirects.

Parameters:
- AW, 10, instruction address width (matches PC width).
- IW, 16, instruction word width.
- DEPTH, 4, FIFO entries; power of two, minimum 2.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-low reset.
- instr_address  input  AW  current PC value.
- branch  input  1  redirect taken this cycle; PC loads the target on the same edge.
- stall  output  1  to PC; 1 = PC must hold.
- mem_req  output  1  instruction memory request.
- mem_addr  output  AW  request address.
- mem_ready  input  1  memory completes the request this cycle; mem_rdata is valid.
- mem_rdata  input  IW  instruction word.
- dec_valid  output  1  FIFO head valid.
- dec_instr  output  IW  FIFO head instruction.
- dec_pc  output  AW  FIFO head address.
- dec_ready  input  1  decode accepts the head this cycle.

Behaviour:
- Reset: sampled only on the rising clk edge while reset==0. Clears state to FETCH, count, rd_ptr, wr_ptr and drain_addr to 0. While reset==0, mem_req=0 and stall=1 are forced combinationally. dec_valid=0 the cycle after reset is sampled.
- Memory protocol:
  - Once mem_req=1 is raised, mem_addr stays stable and mem_req stays high until the cycle mem_ready=1.
  - A request is never withdrawn except by reset.
  - At most one request is outstanding.
- FSM, 2 states:
  - FETCH:
    - mem_req = (count < DEPTH); mem_addr = instr_address.
    - complete = mem_req & mem_ready.
  - DRAIN:
    - mem_req = 1; mem_addr = drain_addr; mem_rdata is discarded.
    - On mem_ready -> FETCH.
- Transitions:
  - FETCH, branch=1, mem_req=1, mem_ready=0: capture drain_addr <= instr_address, go to DRAIN.
  - FETCH, branch=1 with complete=1: the data is discarded (no push); stay in FETCH.
  - DRAIN, branch=1: stay in DRAIN (the in-flight request is unchanged); FIFO is flushed.
- stall (combinational): stall = !(state==FETCH & complete & !branch). The PC ignores stall when branch=1.
- FIFO push: push = (state==FETCH) & complete & !branch. Writes {instr_address, mem_rdata} at wr_ptr.
  - Push is allowed only when the registered count < DEPTH.
  - No same-cycle pass-through when full, even if a pop occurs.
- FIFO pop: pop = dec_valid & dec_ready & !branch.
  - dec_valid = (count != 0).
  - dec_instr/dec_pc are the head entry, driven from registers.
- Latency: an instruction appears at dec_* the cycle after its completion cycle.
- Count update: push and pop in the same cycle leaves count unchanged. Pointers wrap modulo DEPTH.
- Flush: branch=1 sets count, rd_ptr and wr_ptr to 0 on that edge. Flush overrides any push or pop in the same cycle.
- Full: with count==DEPTH in FETCH, mem_req=0 and stall=1. Fetch resumes the cycle after the first pop.
- Reset mid-DRAIN: the abandoned request is dropped; memory is reset system-wide in the same cycle.
- Address arithmetic: the FIFO stores instr_address unmodified. Wrap from 0x3FF to 0x000 is the PC's concern, not this block's.

Test Plan:
1. Reset low 2 cycles, then high; mem_ready=1 and dec_ready=1 constantly, mem holds word 0xA000+addr.
   - Expected: mem_addr 0,1,2,3 on consecutive cycles, stall=0 each cycle.
   - Expected: dec_pc/dec_instr = 0/0xA000 one cycle after the first completion.
2. dec_ready=0, mem_ready=1.
   - Expected: 4 pushes (addresses 0..3), then mem_req=0, stall=1, dec_pc=0 held.
   - Pulse dec_ready for 1 cycle: expected dec_pc=1 next; mem_req=1 with mem_addr=4 on the next cycle.
3. mem_ready returns 3 cycles after req for addr 2.
   - Expected: mem_addr=2 stable for 3 cycles; stall=1,1,0; exactly one push, of {2, word}.
4. Addr 5 pending (mem_ready=0); branch=1 with target 0x040.
   - Expected: next cycle dec_valid=0, state DRAIN, mem_addr=5 held.
   - mem_ready after 2 cycles: no push; next cycle mem_addr=0x040.
5. branch=1 in the same cycle as completion of addr 7 with FIFO holding 3 entries.
   - Expected: no push, count=0 next cycle, mem_addr=target next cycle, no DRAIN.
6. FIFO holding 2 entries, in DRAIN; reset low 1 cycle.
   - Expected: mem_req=0 and stall=1 during reset; dec_valid=0 after.
   - After release: FETCH at instr_address with mem_req=1.

Source files
------------

// File: rtl/fetch_queue.sv
// fetch_queue: consumer side of the program-counter interface.
// Fetches the word at instr_address from instruction memory, buffers
// {pc, instruction} pairs in a small FIFO toward decode, stalls the PC
// while no fetch completes, and flushes on branch redirects.
//
// Handshakes:
//   memory: a transfer happens on a cycle with mem_req=1 and mem_ready=1.
//           Once raised, mem_req stays high with mem_addr stable until that
//           cycle; only reset withdraws a request; at most one is in flight.
//   decode: a transfer happens on a cycle with dec_valid=1 and dec_ready=1
//           and no branch; dec_valid never depends on dec_ready.
module fetch_queue #(
    parameter int unsigned AW    = 10,
    parameter int unsigned IW    = 16,
    parameter int unsigned DEPTH = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [AW-1:0] instr_address,
    input  logic          branch,
    output logic          stall,
    output logic          mem_req,
    output logic [AW-1:0] mem_addr,
    input  logic          mem_ready,
    input  logic [IW-1:0] mem_rdata,
    output logic          dec_valid,
    output logic [IW-1:0] dec_instr,
    output logic [AW-1:0] dec_pc,
    input  logic          dec_ready,
    output logic          dbg_state
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH + 1);

    typedef enum logic {
        FETCH = 1'b0,
        DRAIN = 1'b1
    } state_t;

    state_t          state;
    state_t          next_state;
    logic [CW-1:0]   count;
    logic [PW-1:0]   rd_ptr;
    logic [PW-1:0]   wr_ptr;
    logic [AW-1:0]   drain_addr;
    logic            complete;
    logic            push;
    logic            pop;
    logic            enter_drain;

    logic [AW-1:0]   pc_mem    [DEPTH];
    logic [IW-1:0]   instr_mem [DEPTH];

    // Next state and memory-side outputs; reset forces the request low.
    always_comb begin
        next_state  = state;
        mem_req     = 1'b0;
        mem_addr    = instr_address;
        enter_drain = 1'b0;
        case (state)
            FETCH: begin
                mem_req  = (count < CW'(DEPTH));
                mem_addr = instr_address;
                // A redirect with the request still open must let that
                // request finish before fetching from the new target.
                if (branch && mem_req && !mem_ready) begin
                    enter_drain = 1'b1;
                    next_state  = DRAIN;
                end
            end
            DRAIN: begin
                mem_req  = 1'b1;
                mem_addr = drain_addr;
                if (mem_ready) begin
                    next_state = FETCH;
                end
            end
            default: begin
                next_state = FETCH;
            end
        endcase
        if (!reset) begin
            mem_req     = 1'b0;
            enter_drain = 1'b0;
        end
    end

    assign complete  = (state == FETCH) && mem_req && mem_ready;
    assign push      = complete && !branch;
    assign stall     = !push;
    assign dec_valid = (count != '0);
    assign pop       = dec_valid && dec_ready && !branch;
    assign dec_pc    = pc_mem[rd_ptr];
    assign dec_instr = instr_mem[rd_ptr];
    assign dbg_state = state;

    // State, drain address and FIFO bookkeeping; a branch flush wins over push/pop.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state      <= FETCH;
            count      <= '0;
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            drain_addr <= '0;
        end else begin
            state <= next_state;
            if (enter_drain) begin
                drain_addr <= instr_address;
            end
            if (branch) begin
                count  <= '0;
                rd_ptr <= '0;
                wr_ptr <= '0;
            end else begin
                if (push) begin
                    wr_ptr <= wr_ptr + PW'(1);
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + PW'(1);
                end
                case ({push, pop})
                    2'b10:   count <= count + CW'(1);
                    2'b01:   count <= count - CW'(1);
                    default: count <= count;
                endcase
            end
        end
    end

    // FIFO storage: the fetched word is written next to its unmodified address.
    always_ff @(posedge clk) begin
        if (push) begin
            pc_mem[wr_ptr]    <= instr_address;
            instr_mem[wr_ptr] <= mem_rdata;
        end
    end

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue: a PC model and a word-per-address memory
// surround the block; expected decode entries go into exp_q when stimulus
// is issued and a negedge monitor pops and compares every decode transfer.
module tb_fetch_queue;

    localparam int AW = 10;
    localparam int IW = 16;

    logic          clk;
    logic          reset;
    logic [AW-1:0] instr_address;
    logic          branch;
    logic          stall;
    logic          mem_req;
    logic [AW-1:0] mem_addr;
    logic          mem_ready;
    logic [IW-1:0] mem_rdata;
    logic          dec_valid;
    logic [IW-1:0] dec_instr;
    logic [AW-1:0] dec_pc;
    logic          dec_ready;
    logic          dbg_state;

    logic [AW-1:0]    target;
    logic [AW+IW-1:0] exp_q[$];
    logic [AW+IW-1:0] mon_e;
    int               checks = 0;
    int               errors = 0;

    fetch_queue #(.AW(AW), .IW(IW), .DEPTH(4)) dut (
        .clk           (clk),
        .reset         (reset),
        .instr_address (instr_address),
        .branch        (branch),
        .stall         (stall),
        .mem_req       (mem_req),
        .mem_addr      (mem_addr),
        .mem_ready     (mem_ready),
        .mem_rdata     (mem_rdata),
        .dec_valid     (dec_valid),
        .dec_instr     (dec_instr),
        .dec_pc        (dec_pc),
        .dec_ready     (dec_ready),
        .dbg_state     (dbg_state)
    );

    // Clock and memory contents: word at address a is 0xA000 + a.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    assign mem_rdata = 16'hA000 + 16'(mem_addr);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    task automatic exp_push(input logic [AW-1:0] a);
        logic [IW-1:0] w;
        w = 16'hA000 + 16'(a);
        exp_q.push_back({a, w});
    endtask

    task automatic sync();
        @(negedge clk);
    endtask

    // Driver: call at the negedge; advances one clock and updates the PC model
    // (reset -> 0, branch -> target, otherwise +1 unless stalled).
    task automatic adv();
        logic          s;
        logic          b;
        logic          r;
        logic [AW-1:0] t;
        s = stall;
        b = branch;
        r = reset;
        t = target;
        @(posedge clk);
        #1;
        if (!r)      instr_address = '0;
        else if (b)  instr_address = t;
        else if (!s) instr_address = instr_address + AW'(1);
        branch = 1'b0;
    endtask

    // Scoreboard monitor: every accepted decode entry must match the queue head.
    always @(negedge clk) begin
        if (reset === 1'b1 && dec_valid === 1'b1 && dec_ready === 1'b1 && branch === 1'b0) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL dec_pop: got pc=0x%0h instr=0x%0h, required no entry", dec_pc, dec_instr);
            end else begin
                mon_e = exp_q.pop_front();
                if ({dec_pc, dec_instr} !== mon_e) begin
                    errors++;
                    $display("FAIL dec_pop: got pc=0x%0h instr=0x%0h, required pc=0x%0h instr=0x%0h",
                             dec_pc, dec_instr, mon_e[AW+IW-1:IW], mon_e[IW-1:0]);
                end
            end
        end
    end

    initial begin
        #50000;
        $display("FAIL watchdog: simulation did not finish, required finish before 50000");
        $fatal(1);
    end

    initial begin
        reset         = 1'b0;
        branch        = 1'b0;
        target        = '0;
        instr_address = '0;
        mem_ready     = 1'b1;
        dec_ready     = 1'b1;

        // Reset held for two edges: request forced low, stall forced high.
        sync();
        chk("rst_mem_req", mem_req, 0);
        chk("rst_stall", stall, 1);
        chk("rst_dec_valid", dec_valid, 0);
        adv();
        reset = 1'b1;

        // Streaming: one fetch per cycle, decode drains each entry a cycle later.
        for (int i = 0; i < 4; i++) exp_push(AW'(i));
        for (int i = 0; i < 4; i++) begin
            sync();
            chk("stream_mem_req", mem_req, 1);
            chk("stream_mem_addr", mem_addr, i);
            chk("stream_stall", stall, 0);
            chk("stream_dec_valid", dec_valid, (i == 0) ? 0 : 1);
            adv();
        end

        // Decode blocked: fill to DEPTH, then fetch stops.
        dec_ready = 1'b0;
        for (int i = 4; i < 7; i++) exp_push(AW'(i));
        for (int i = 0; i < 3; i++) begin
            sync();
            chk("fill_mem_req", mem_req, 1);
            chk("fill_mem_addr", mem_addr, 4 + i);
            adv();
        end
        sync();
        chk("full_mem_req", mem_req, 0);
        chk("full_stall", stall, 1);
        chk("full_dec_pc", dec_pc, 3);
        adv();
        dec_ready = 1'b1;
        sync();
        chk("full_pop_mem_req", mem_req, 0);
        adv();
        dec_ready = 1'b0;
        exp_push(AW'(7));
        sync();
        chk("resume_dec_pc", dec_pc, 4);
        chk("resume_mem_req", mem_req, 1);
        chk("resume_mem_addr", mem_addr, 7);
        chk("resume_stall", stall, 0);
        adv();

        // Slow memory: drain the FIFO, then complete addr 8 after three cycles.
        dec_ready = 1'b1;
        mem_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            sync();
            if (i == 0) begin
                chk("slow_full_mem_req", mem_req, 0);
            end else begin
                chk("slow_wait_mem_addr", mem_addr, 8);
                chk("slow_wait_stall", stall, 1);
            end
            adv();
        end
        exp_push(AW'(8));
        for (int j = 0; j < 3; j++) begin
            mem_ready = (j == 2);
            sync();
            chk("slow_mem_addr", mem_addr, 8);
            chk("slow_stall", stall, (j != 2) ? 1 : 0);
            adv();
        end
        mem_ready = 1'b0;
        sync();
        chk("slow_dec_valid", dec_valid, 1);
        chk("slow_dec_pc", dec_pc, 8);
        chk("slow_next_addr", mem_addr, 9);
        adv();

        // Branch with addr 9 in flight: drain the old request, discard its data.
        branch = 1'b1;
        target = 10'h040;
        sync();
        chk("br_one_push_only", dec_valid, 0);
        chk("br_mem_addr", mem_addr, 9);
        chk("br_stall", stall, 1);
        adv();
        sync();
        chk("drain_state", dbg_state, 1);
        chk("drain_mem_addr", mem_addr, 9);
        chk("drain_dec_valid", dec_valid, 0);
        adv();
        mem_ready = 1'b1;
        sync();
        chk("drain_done_stall", stall, 1);
        chk("drain_done_addr", mem_addr, 9);
        adv();
        dec_ready = 1'b0;
        exp_push(10'h040);
        sync();
        chk("post_drain_state", dbg_state, 0);
        chk("post_drain_addr", mem_addr, 10'h040);
        chk("post_drain_no_push", dec_valid, 0);
        adv();

        // Branch on the completion cycle of 0x043 with three entries buffered.
        for (int i = 1; i < 3; i++) begin
            exp_push(AW'(10'h040 + i));
            sync();
            chk("fill3_mem_addr", mem_addr, 10'h040 + i);
            adv();
        end
        branch = 1'b1;
        target = 10'h100;
        exp_q.delete();
        sync();
        chk("brc_mem_addr", mem_addr, 10'h043);
        chk("brc_dec_pc", dec_pc, 10'h040);
        chk("brc_stall", stall, 1);
        adv();
        exp_push(10'h100);
        sync();
        chk("brc_flushed", dec_valid, 0);
        chk("brc_state", dbg_state, 0);
        chk("brc_mem_addr_target", mem_addr, 10'h100);
        adv();

        // Reset with two entries buffered, then reset while draining.
        exp_push(10'h101);
        sync();
        chk("pre_rst_mem_addr", mem_addr, 10'h101);
        adv();
        mem_ready = 1'b0;
        reset     = 1'b0;
        exp_q.delete();
        sync();
        chk("rst2_mem_req", mem_req, 0);
        chk("rst2_stall", stall, 1);
        chk("rst2_dec_valid_before", dec_valid, 1);
        chk("rst2_dec_pc_before", dec_pc, 10'h100);
        adv();
        reset  = 1'b1;
        branch = 1'b1;
        target = 10'h300;
        sync();
        chk("rst2_dec_valid_after", dec_valid, 0);
        chk("rst2_state", dbg_state, 0);
        chk("rst2_mem_req_after", mem_req, 1);
        chk("rst2_mem_addr_after", mem_addr, 0);
        adv();
        reset = 1'b0;
        sync();
        chk("rst3_in_drain", dbg_state, 1);
        chk("rst3_mem_req", mem_req, 0);
        chk("rst3_stall", stall, 1);
        adv();
        reset = 1'b1;
        sync();
        chk("rst3_state_after", dbg_state, 0);
        chk("rst3_mem_req_after", mem_req, 1);
        chk("rst3_mem_addr_after", mem_addr, 0);
        chk("rst3_dec_valid_after", dec_valid, 0);
        chk("rst3_stall_after", stall, 1);

        chk("exp_q_empty", 32'(exp_q.size()), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
